pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the KGP-RISC fetch stage; successor to the plain PC register.
//  Holds the current fetch address and selects the next one from sequential, branch, jump, call and return sources.
//  Adds stall, a halt/resume state machine and an optional return-address stack (RAS).
//  Sits between the branch/control logic and the instruction memory address port.
// PARAMETERS
//  ADDR_W     32  width of PC and all address ports
//  INC        4   sequential increment (bytes per instruction)
//  RESET_VEC  0   PC value loaded on reset
//  RAS_DEPTH  8   RAS entries (power of 2, >=2); used only with PC_RAS_EN
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  stall       in   1       hold PC this cycle (pipeline bubble)
//  halt_req    in   1       request transition RUN->HALT
//  resume      in   1       request transition HALT->RUN
//  br_taken    in   1       conditional branch resolved taken
//  br_target   in   ADDR_W  branch destination
//  jmp         in   1       unconditional jump
//  call        in   1       jump to jmp_target and push return address
//  ret         in   1       return: jump to popped RAS address
//  jmp_target  in   ADDR_W  destination for jmp/call (and ret fallback)
//  pc_out      out  ADDR_W  current fetch address (registered)
//  pc_next     out  ADDR_W  combinational next-PC the unit will load if not held
//  running     out  1       1 in RUN state
//  ras_full    out  1       RAS holds RAS_DEPTH entries
//  ras_empty   out  1       RAS holds 0 entries
//  ras_err     out  1       1-cycle pulse: push-on-full or pop-on-empty
// BEHAVIOUR
//  - Reset (reset=0, async): pc_out=RESET_VEC, state=RUN, running=1, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
//  - FSM: RUN --halt_req--> HALT; HALT --resume--> RUN. halt_req has priority if both are asserted in RUN.
//    The edge that enters HALT does not update PC; the edge that leaves HALT does not update PC; updates resume on the next edge.
//  - PC loads pc_next on each rising edge when state=RUN, stall=0 and halt_req=0; otherwise PC holds and the RAS is unchanged.
//  - pc_next priority: ret > call > jmp > br_taken > pc_out+INC.
//    ret -> RAS top (jmp_target if RAS empty); call/jmp -> jmp_target; br_taken -> br_target.
//  - pc_out+INC wraps modulo 2^ADDR_W (carry discarded). Targets are loaded unmodified; no alignment check.
//  - RAS push (call): stores pc_out+INC. Push when full overwrites the oldest entry (circular).
//    Count stays RAS_DEPTH; ras_err pulses.
//  - RAS pop (ret) when empty: jump to jmp_target, count stays 0, ras_err pulses.
//  - call & ret together: pc_next = old top (ret priority). Top is replaced by pc_out+INC; count unchanged.
//    If empty, this acts as a push and the target is jmp_target.
//  - ras_err is registered: asserted the cycle after the offending update; cleared otherwise.
//  - Latency: pc_out reflects a redirect one cycle after the control input is sampled.
// CONFIGURATION
//  PC_RAS_EN defined: RAS built as above.
//  PC_RAS_EN undefined: no RAS storage. call and ret behave exactly as jmp (target jmp_target).
//    ras_full=0, ras_empty=1, ras_err=0 constantly; RAS_DEPTH is ignored.
// TESTING
//  1. reset=0 mid-run, INC=4, RESET_VEC=0x100 -> pc_out=0x100 immediately (async); released -> 0x104, 0x108 on next edges.
//  2. pc_out=0xFFFFFFFC, no controls -> pc_out=0x00000000 next edge (wrap).
//  3. pc_out=0x200, br_taken=1 + jmp=1 (jmp_target=0x400, br_target=0x300) -> 0x400. stall=1 next cycle -> holds 0x400.
//  4. halt_req at pc=0x10 -> running=0, pc stays 0x10 across 5 edges. resume -> 0x10 one more edge, then 0x14.
//  5. PC_RAS_EN, RAS_DEPTH=2: calls at 0x10, 0x20, 0x30 -> ras_full=1, ras_err pulse on 3rd.
//     rets -> 0x34, 0x24, then empty: ret jumps to jmp_target with ras_err pulse.
//  6. Without PC_RAS_EN: call with jmp_target=0x80 -> pc_out=0x80, ras_empty=1, ras_err=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: KGP-RISC fetch-stage program counter with stall, a halt/resume FSM
// and an optional return-address stack, built only when PC_RAS_EN is defined.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INC       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_halt_req,
    input  logic              i_resume,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_jmp,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic [ADDR_W-1:0] i_jmp_target,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_running,
    output logic              o_ras_full,
    output logic              o_ras_empty,
    output logic              o_ras_err
);

    typedef enum logic {S_RUN, S_HALT} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_ret_target;
    logic              w_update;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_unit: RAS_DEPTH must be a power of 2 and at least 2");
    end

    // Halt entry and exit edges both suppress the PC update.
    assign w_update = (r_state == S_RUN) && !i_stall && !i_halt_req;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_RUN;
        else          r_state <= w_state_next;
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (i_halt_req) w_state_next = S_HALT;
            S_HALT:  if (i_resume)   w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        w_pc_inc  = r_pc + ADDR_W'(INC);
        w_pc_next = w_pc_inc;
        if (i_ret)                 w_pc_next = w_ret_target;
        else if (i_call || i_jmp)  w_pc_next = i_jmp_target;
        else if (i_br_taken)       w_pc_next = i_br_target;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)      r_pc <= RESET_VEC;
        else if (w_update) r_pc <= w_pc_next;
    end

`ifdef PC_RAS_EN
    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [CNT_W-1:0]  r_count;
    logic              r_ras_err;
    logic [SP_W-1:0]   w_top_idx;
    logic              w_ras_empty;
    logic              w_ras_full;

    // r_sp is the next write slot; once full it also indexes the oldest entry.
    assign w_top_idx    = r_sp - SP_W'(1);
    assign w_ras_empty  = (r_count == '0);
    assign w_ras_full   = (r_count == CNT_W'(RAS_DEPTH));
    assign w_ret_target = w_ras_empty ? i_jmp_target : r_ras[w_top_idx];

    // NOTE: the stack storage has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge i_clock) begin
        if (w_update && i_call) begin
            if (i_ret && !w_ras_empty) r_ras[w_top_idx] <= w_pc_inc;
            else                       r_ras[r_sp]      <= w_pc_inc;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sp      <= '0;
            r_count   <= '0;
            r_ras_err <= 1'b0;
        end else begin
            r_ras_err <= 1'b0;
            if (w_update) begin
                if (i_call && i_ret) begin
                    if (w_ras_empty) begin
                        r_sp    <= r_sp + SP_W'(1);
                        r_count <= CNT_W'(1);
                    end
                end else if (i_call) begin
                    r_sp <= r_sp + SP_W'(1);
                    if (w_ras_full) r_ras_err <= 1'b1;
                    else            r_count   <= r_count + CNT_W'(1);
                end else if (i_ret) begin
                    if (w_ras_empty) begin
                        r_ras_err <= 1'b1;
                    end else begin
                        r_sp    <= w_top_idx;
                        r_count <= r_count - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_ras_full  = w_ras_full;
    assign o_ras_empty = w_ras_empty;
    assign o_ras_err   = r_ras_err;
`else
    assign w_ret_target = i_jmp_target;
    assign o_ras_full   = 1'b0;
    assign o_ras_empty  = 1'b1;
    assign o_ras_err    = 1'b0;
`endif

    assign o_pc_out  = r_pc;
    assign o_pc_next = w_pc_next;
    assign o_running = (r_state == S_RUN);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; a queue-based reference model
// predicts each cycle and a separate monitor compares DUT outputs.
module tb_pc_unit;

    localparam int          ADDR_W    = 32;
    localparam int          INC       = 4;
    localparam logic [31:0] RESET_VEC = 32'h100;
    localparam int          RAS_DEPTH = 2;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic        br_taken = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] br_target = '0, jmp_target = '0;
    logic [31:0] pc_out, pc_next;
    logic        running, ras_full, ras_empty, ras_err;

    pc_unit #(
        .ADDR_W(ADDR_W), .INC(INC), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .i_halt_req(halt_req),
        .i_resume(resume), .i_br_taken(br_taken), .i_br_target(br_target),
        .i_jmp(jmp), .i_call(call), .i_ret(ret), .i_jmp_target(jmp_target),
        .o_pc_out(pc_out), .o_pc_next(pc_next), .o_running(running),
        .o_ras_full(ras_full), .o_ras_empty(ras_empty), .o_ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nxt;
        logic [31:0] pc;
        logic        run;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state: the RAS is an ordered list, newest at the back.
    logic [31:0] m_pc  = RESET_VEC;
    logic        m_run = 1'b1;
    logic        m_err = 1'b0;
    logic [31:0] m_ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RESET_VEC;
        m_run = 1'b1;
        m_err = 1'b0;
        m_ras.delete();
    endtask

    task automatic step(input logic st, input logic hr, input logic rs, input logic br,
                        input logic j, input logic c, input logic r,
                        input logic [31:0] bt, input logic [31:0] jt);
        exp_t        e;
        logic [31:0] seq;
        logic        upd;
        @(negedge clk);
        rst_n = 1'b1;
        stall = st; halt_req = hr; resume = rs; br_taken = br;
        jmp = j; call = c; ret = r; br_target = bt; jmp_target = jt;

        seq = m_pc + 32'(INC);
        if (r)          e.nxt = (RAS_EN && m_ras.size() > 0) ? m_ras[$] : jt;
        else if (c || j) e.nxt = jt;
        else if (br)    e.nxt = bt;
        else            e.nxt = seq;

        upd   = m_run && !st && !hr;
        m_err = 1'b0;
        if (upd) begin
            m_pc = e.nxt;
            if (RAS_EN) begin
                if (c && r) begin
                    if (m_ras.size() == 0) m_ras.push_back(seq);
                    else                   m_ras[$] = seq;
                end else if (c) begin
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1'b1;
                    end
                    m_ras.push_back(seq);
                end else if (r) begin
                    if (m_ras.size() == 0) m_err = 1'b1;
                    else                   void'(m_ras.pop_back());
                end
            end
        end
        if (m_run && hr)       m_run = 1'b0;
        else if (!m_run && rs) m_run = 1'b1;

        e.pc    = m_pc;
        e.run   = m_run;
        e.full  = RAS_EN && (m_ras.size() == RAS_DEPTH);
        e.empty = !RAS_EN || (m_ras.size() == 0);
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_out", pc_out, RESET_VEC);
        check("rst_running", 32'(running), 32'd1);
        check("rst_ras_empty", 32'(ras_empty), 32'd1);
        check("rst_ras_full", 32'(ras_full), 32'd0);
        check("rst_ras_err", 32'(ras_err), 32'd0);
    endtask

    // Monitor: pc_next is sampled before the edge, registered outputs after it.
    initial begin : monitor
        exp_t        e;
        logic [31:0] nxt_s;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                nxt_s = pc_next;
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check("pc_next", nxt_s, e.nxt);
                check("pc_out", pc_out, e.pc);
                check("running", 32'(running), 32'(e.run));
                check("ras_full", 32'(ras_full), 32'(e.full));
                check("ras_empty", 32'(ras_empty), 32'(e.empty));
                check("ras_err", 32'(ras_err), 32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        check_reset_outputs();
        idle(2);

        // Asynchronous reset in the middle of a run, sampled away from any edge.
        idle(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        idle(2);

        // Sequential wrap at the top of the address space.
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC);
        idle(2);

        // Jump beats branch, then a stall holds the PC.
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h200);
        step(0, 0, 0, 1, 1, 0, 0, 32'h300, 32'h400);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Halt for several edges, then resume.
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h10);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(5);
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(2);
        step(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 0, 0, 0, 32'h50, 32'h0);
        step(0, 0, 0, 1, 0, 0, 0, 32'h50, 32'h0);

        // RAS overflow, unwinding, and pop on empty.
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h10);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h20);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h30);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h40);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h900);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h900);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h500);

        // Simultaneous call and return, on a non-empty and on an empty stack.
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h600);
        step(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h700);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h800);
        step(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'hA00);
        step(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hB00);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'hC00);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h80);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(3) == 0,
                 $urandom_range(4) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
                 $urandom_range(4) == 0, $urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
